uart_host_seq: RTL and testbench
================================

// Module: uart_host_seq
// PURPOSE
//  Register-bus initiator that drives the UART peripheral's register interface (ren/we/addr/wdata/rdata).
//  After reset it programs the baud divisor and enables RX.
//  It then moves bytes between two valid/ready streams and the peripheral's TX/RX FIFOs.
//  Sits between a hardware client (debug bridge, loader) and the UART, replacing software polling.
// PARAMETERS
//  CLKS_PER_BIT  16'd868  baud divisor written to CPB (addr 0) during configuration
//  MAX_BURST     8        max TX bytes loaded into the TX FIFO before a kick; 1..255
//  RD_LAT        1        cycles from a read strobe until rdata_i is valid; 0 or 1
// PORTS
//  clk_i         in   1   clock
//  rst_ni        in   1   asynchronous active-low reset
//  tx_valid_i    in   1   client byte available
//  tx_data_i     in   8   client byte
//  tx_ready_o    out  1   byte accepted when tx_valid_i & tx_ready_o
//  rx_valid_o    out  1   received byte available, held until taken
//  rx_data_o     out  8   received byte
//  rx_ready_i    in   1   client takes byte when rx_valid_o & rx_ready_i
//  busy_o        out  1   state != IDLE
//  ren_o         out  1   peripheral read strobe (one cycle per access)
//  we_o          out  1   peripheral write strobe (one cycle per access)
//  addr_o        out  8   peripheral register byte address
//  wdata_o       out  32  peripheral write data
//  rdata_i       in   32  peripheral read data
//  intr_tx_i     in   1   peripheral TX-complete pulse (TX FIFO drained)
//  intr_rx_i     in   1   peripheral RX interrupt (informational; polling is authoritative)
// BEHAVIOUR
//  Reset: all outputs 0. State=CFG_CPB; byte counter=0; rx holding reg empty.
//  Bus rules:
//   - At most one of ren_o/we_o high per cycle; never both.
//   - Each access is exactly one cycle.
//   - Outside an access, addr_o and wdata_o are 0.
//   - Reads sample rdata_i RD_LAT cycles after ren_o.
//  FSM (one bus write per state unless noted):
//   CFG_CPB    wr addr 0  = CLKS_PER_BIT -> CFG_RXB
//   CFG_RXB    wr addr 56 = 1 (per-byte RX irq) -> CFG_RXEN
//   CFG_RXEN   wr addr 12 = 1 -> IDLE
//   IDLE       priority: pending RX poll > TX. rx poll pending when intr_rx_i seen or a 64-cycle poll timer expires.
//              If rx holding reg empty and a poll is pending -> RX_SIZE.
//              Else if tx_valid_i -> TX_LOAD. Else stay.
//   RX_SIZE    rd addr 52, wait RD_LAT. rdata_i[7:0]==0 -> IDLE (clear poll pending); else -> RX_READ.
//   RX_READ    rd addr 8, wait RD_LAT, capture rdata_i[7:0] into holding reg, rx_valid_o=1 -> IDLE (poll stays pending).
//   TX_LOAD    tx_ready_o=1. Each accepted byte is written the same cycle: we_o=1, addr 4, wdata_o={24'b0,byte}; count++.
//              Go to TX_INIT when count==MAX_BURST, or tx_valid_i low with count>0.
//   TX_INIT    wr addr 28 = 1 -> TX_EN
//   TX_EN      wr addr 16 = 1 -> TX_WAIT
//   TX_WAIT    wait intr_tx_i; then count=0 -> IDLE. RX polls are deferred meanwhile; intr_rx_i is latched.
//  tx_ready_o is high only in TX_LOAD, combinationally with the write strobe.
//  rx_valid_o stays high until the handshake; the holding reg clears on handshake. No new RX read while it is full.
//  RX bytes are delivered to the client in peripheral FIFO order; none dropped or duplicated.
//  intr_rx_i arriving during any state sets poll pending (sticky until RX_SIZE returns 0).
//  Reset mid-operation: immediate return to reset values; configuration reruns in full.
//  Counter width: 8 bits. MAX_BURST=255 must not wrap.
// TESTING
//  Reset release, CLKS_PER_BIT=16 -> writes (0,16),(56,1),(12,1) on cycles 1..3, then busy_o=0.
//  3 bytes 0x41,0x42,0x43 streamed back-to-back -> 3 writes addr 4, then (28,1),(16,1); tx_o serial matches; busy_o drops after intr_tx_i.
//  10 bytes with MAX_BURST=8 -> two bursts (8 then 2), each ending with its own intr_tx_i wait.
//  Loopback tx_o->rx_i, send 0xA5 -> rx_valid_o=1 with rx_data_o=0xA5 exactly once.
//  rx_ready_i held low while 2 bytes arrive -> second not read until first taken; both delivered in order.
//  Assert rst_ni low during TX_WAIT -> all outputs 0 next edge; config sequence repeats after release.

Source files
------------

// File: rtl/uart_host_seq.sv
// Register-bus initiator for the UART peripheral: programs it after reset, then moves
// client TX bytes into the TX FIFO and polls the RX FIFO into a one-byte holding register.
module uart_host_seq #(
  parameter logic [15:0] CLKS_PER_BIT = 16'd868,
  parameter int unsigned MAX_BURST    = 8,
  parameter int unsigned RD_LAT       = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tx_valid_i,
  input  logic [7:0]  tx_data_i,
  output logic        tx_ready_o,
  output logic        rx_valid_o,
  output logic [7:0]  rx_data_o,
  input  logic        rx_ready_i,
  output logic        busy_o,
  output logic        ren_o,
  output logic        we_o,
  output logic [7:0]  addr_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] rdata_i,
  input  logic        intr_tx_i,
  input  logic        intr_rx_i
);

  typedef enum logic [3:0] {
    S_CFG_CPB, S_CFG_RXB, S_CFG_RXEN, S_IDLE, S_RX_SIZE,
    S_RX_READ, S_TX_LOAD, S_TX_INIT, S_TX_EN, S_TX_WAIT
  } state_e;

  localparam logic [7:0] ADDR_CPB    = 8'd0;
  localparam logic [7:0] ADDR_TXD    = 8'd4;
  localparam logic [7:0] ADDR_RXD    = 8'd8;
  localparam logic [7:0] ADDR_RXEN   = 8'd12;
  localparam logic [7:0] ADDR_TXEN   = 8'd16;
  localparam logic [7:0] ADDR_TXINIT = 8'd28;
  localparam logic [7:0] ADDR_RXSZ   = 8'd52;
  localparam logic [7:0] ADDR_RXIRQ  = 8'd56;
  localparam logic [7:0] BURST_LAST  = 8'(MAX_BURST - 1);

  state_e      state_q, state_d;
  logic        run_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        poll_q, poll_d;
  logic [5:0]  tmr_q;
  logic        rd_wait_q, rd_wait_d;
  logic        hold_v_q, hold_v_d;
  logic [7:0]  hold_q, hold_d;
  logic        rd_sample;
  logic        poll_set;
  logic        rx_take;
  logic [23:0] unused_rdata;

  assign unused_rdata = rdata_i[31:8];
  // With RD_LAT=1 the read strobe cycle is followed by one sampling cycle.
  assign rd_sample  = (RD_LAT == 0) ? 1'b1 : rd_wait_q;
  assign poll_set   = intr_rx_i | (tmr_q == '1);
  assign rx_take    = hold_v_q & rx_ready_i;
  assign rx_valid_o = hold_v_q;
  assign rx_data_o  = hold_q;
  assign busy_o     = run_q & (state_q != S_IDLE);

  // Outputs stay at zero until the first edge after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_CFG_CPB;
      run_q     <= 1'b0;
      cnt_q     <= '0;
      poll_q    <= 1'b0;
      tmr_q     <= '0;
      rd_wait_q <= 1'b0;
      hold_v_q  <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      cnt_q     <= cnt_d;
      poll_q    <= poll_d;
      tmr_q     <= tmr_q + 6'd1;
      rd_wait_q <= rd_wait_d;
      hold_v_q  <= hold_v_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    poll_d     = poll_q | poll_set;
    rd_wait_d  = rd_wait_q;
    hold_v_d   = hold_v_q & ~rx_ready_i;
    hold_d     = rx_take ? '0 : hold_q;
    ren_o      = 1'b0;
    we_o       = 1'b0;
    addr_o     = '0;
    wdata_o    = '0;
    tx_ready_o = 1'b0;
    if (run_q) begin
      case (state_q)
        S_CFG_CPB: begin
          we_o    = 1'b1;
          addr_o  = ADDR_CPB;
          wdata_o = {16'b0, CLKS_PER_BIT};
          state_d = S_CFG_RXB;
        end
        S_CFG_RXB: begin
          we_o    = 1'b1;
          addr_o  = ADDR_RXIRQ;
          wdata_o = 32'd1;
          state_d = S_CFG_RXEN;
        end
        S_CFG_RXEN: begin
          we_o    = 1'b1;
          addr_o  = ADDR_RXEN;
          wdata_o = 32'd1;
          state_d = S_IDLE;
        end
        S_IDLE: begin
          if (!hold_v_q && poll_q) state_d = S_RX_SIZE;
          else if (tx_valid_i)     state_d = S_TX_LOAD;
        end
        S_RX_SIZE: begin
          if (!rd_wait_q) begin
            ren_o  = 1'b1;
            addr_o = ADDR_RXSZ;
          end
          if (rd_sample) begin
            rd_wait_d = 1'b0;
            if (rdata_i[7:0] == 8'd0) begin
              state_d = S_IDLE;
              poll_d  = poll_set;
            end else begin
              state_d = S_RX_READ;
            end
          end else begin
            rd_wait_d = 1'b1;
          end
        end
        S_RX_READ: begin
          if (!rd_wait_q) begin
            ren_o  = 1'b1;
            addr_o = ADDR_RXD;
          end
          if (rd_sample) begin
            rd_wait_d = 1'b0;
            hold_d    = rdata_i[7:0];
            hold_v_d  = 1'b1;
            state_d   = S_IDLE;
          end else begin
            rd_wait_d = 1'b1;
          end
        end
        S_TX_LOAD: begin
          tx_ready_o = 1'b1;
          if (tx_valid_i) begin
            we_o    = 1'b1;
            addr_o  = ADDR_TXD;
            wdata_o = {24'b0, tx_data_i};
            cnt_d   = cnt_q + 8'd1;
            if (cnt_q == BURST_LAST) state_d = S_TX_INIT;
          end else if (cnt_q != 8'd0) begin
            state_d = S_TX_INIT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_TX_INIT: begin
          we_o    = 1'b1;
          addr_o  = ADDR_TXINIT;
          wdata_o = 32'd1;
          state_d = S_TX_EN;
        end
        S_TX_EN: begin
          we_o    = 1'b1;
          addr_o  = ADDR_TXEN;
          wdata_o = 32'd1;
          state_d = S_TX_WAIT;
        end
        S_TX_WAIT: begin
          if (intr_tx_i) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_host_seq.sv
// Directed bench for uart_host_seq with a behavioural model of the UART register map.
module tb_uart_host_seq;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        tx_valid_i;
  logic [7:0]  tx_data_i;
  logic        tx_ready_o;
  logic        rx_valid_o;
  logic [7:0]  rx_data_o;
  logic        rx_ready_i;
  logic        busy_o;
  logic        ren_o;
  logic        we_o;
  logic [7:0]  addr_o;
  logic [31:0] wdata_o;
  logic [31:0] rdata_i   = '0;
  logic        intr_tx_i = 1'b0;
  logic        intr_rx_i = 1'b0;

  always #5 clk = ~clk;

  uart_host_seq #(.CLKS_PER_BIT(16'd16), .MAX_BURST(8), .RD_LAT(1)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i), .tx_ready_o(tx_ready_o),
    .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .rx_ready_i(rx_ready_i),
    .busy_o(busy_o), .ren_o(ren_o), .we_o(we_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .rdata_i(rdata_i), .intr_tx_i(intr_tx_i), .intr_rx_i(intr_rx_i)
  );

  localparam logic [7:0]  CFG_A [3] = '{8'd0, 8'd56, 8'd12};
  localparam logic [31:0] CFG_D [3] = '{32'd16, 32'd1, 32'd1};

  int checks   = 0;
  int failures = 0;

  // Peripheral model state; each variable has a single writing process.
  logic [47:0] wlog[$];
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  logic [7:0]  sent[$];
  logic [7:0]  got[$];
  int          nrd8     = 0;
  int          ntx_done = 0;
  int          viol     = 0;
  int          tx_timer = 0;
  bit          loopback = 1'b0;
  bit          hold_tx  = 1'b0;
  logic [7:0]  inj_data [16];
  int          inj_cnt  = 0;
  int          inj_done = 0;

  always @(posedge clk) begin
    intr_tx_i <= 1'b0;
    intr_rx_i <= 1'b0;
    if (!rst_ni) begin
      txq.delete();
      tx_timer <= 0;
    end else begin
      if (we_o) begin
        wlog.push_back({8'(ntx_done), addr_o, wdata_o});
        if (addr_o == 8'd4) txq.push_back(wdata_o[7:0]);
        if (addr_o == 8'd16 && wdata_o[0] && !hold_tx) tx_timer <= 10;
      end
      if (ren_o) begin
        if (addr_o == 8'd52) rdata_i <= 32'(rxq.size());
        else if (addr_o == 8'd8) begin
          nrd8 <= nrd8 + 1;
          if (rxq.size() > 0) begin
            rdata_i <= {24'b0, rxq[0]};
            rxq.delete(0);
          end else rdata_i <= '0;
        end
      end
      if (tx_timer > 0) begin
        tx_timer <= tx_timer - 1;
        if (tx_timer == 1) begin
          intr_tx_i <= 1'b1;
          ntx_done  <= ntx_done + 1;
          foreach (txq[i]) begin
            sent.push_back(txq[i]);
            if (loopback) begin
              rxq.push_back(txq[i]);
              intr_rx_i <= 1'b1;
            end
          end
          txq.delete();
        end
      end
      if (inj_done != inj_cnt) begin
        rxq.push_back(inj_data[inj_done]);
        inj_done  <= inj_done + 1;
        intr_rx_i <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (ren_o && we_o) viol <= viol + 1;
    else if (!ren_o && !we_o && (addr_o != 8'd0 || wdata_o != 32'd0)) viol <= viol + 1;
    if (rx_valid_o && rx_ready_i) got.push_back(rx_data_o);
  end

  task automatic push_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    tx_valid_i = 1'b1;
    tx_data_i  = b;
    repeat (400) begin
      @(negedge clk);
      if (tx_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    tx_valid_i = 1'b0;
    tx_data_i  = '0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy_o, ren_o, we_o, tx_ready_o, rx_valid_o} !== 5'b0 || addr_o !== 8'd0 ||
        wdata_o !== 32'd0 || rx_data_o !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b ren=%b we=%b rdy=%b rxv=%b addr=%h wdata=%h required all 0",
               busy_o, ren_o, we_o, tx_ready_o, rx_valid_o, addr_o, wdata_o);
    end
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (we_o !== 1'b1 || ren_o !== 1'b0 || addr_o !== CFG_A[i] || wdata_o !== CFG_D[i]) begin
        failures++;
        $display("FAIL cfg_write[%0d] got we=%b ren=%b addr=%0d data=%0d required we=1 addr=%0d data=%0d",
                 i, we_o, ren_o, addr_o, wdata_o, CFG_A[i], CFG_D[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || we_o !== 1'b0) begin
      failures++;
      $display("FAIL cfg_idle got busy=%b we=%b required 0 0", busy_o, we_o);
    end
  endtask

  task automatic test_tx3();
    logic [7:0]  bytes [3] = '{8'h41, 8'h42, 8'h43};
    logic [39:0] exp   [5] = '{{8'd4, 32'h41}, {8'd4, 32'h42}, {8'd4, 32'h43},
                                {8'd28, 32'd1}, {8'd16, 32'd1}};
    int base, sbase, nto;
    bit ok, seen;
    logic [39:0] e;
    base = wlog.size(); sbase = sent.size(); nto = 0; seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_byte(bytes[i], ok);
      if (!ok) nto++;
    end
    checks++;
    if (nto != 0) begin failures++; $display("FAIL tx3_accept timeouts=%0d required 0", nto); end
    repeat (300) begin
      @(negedge clk);
      if (intr_tx_i) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL tx3_intr_wait got none required intr_tx_i"); end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL tx3_busy_drop got %b required 0", busy_o); end
    checks++;
    if (wlog.size() - base != 5) begin
      failures++; $display("FAIL tx3_write_count got %0d required 5", wlog.size() - base);
    end
    for (int i = 0; i < 5; i++) begin
      e = (base + i < wlog.size()) ? wlog[base + i][39:0] : '1;
      checks++;
      if (e !== exp[i]) begin failures++; $display("FAIL tx3_write[%0d] got %h required %h", i, e, exp[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      e[7:0] = (sbase + i < sent.size()) ? sent[sbase + i] : 8'hxx;
      checks++;
      if (e[7:0] !== bytes[i]) begin
        failures++; $display("FAIL tx3_serial[%0d] got %h required %h", i, e[7:0], bytes[i]);
      end
    end
  endtask

  task automatic test_burst10();
    int base, sbase, nbase, nto;
    bit ok, seen;
    logic [47:0] e, x;
    base = wlog.size(); sbase = sent.size(); nbase = ntx_done; nto = 0; seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push_byte(8'h30 + 8'(i), ok);
      if (!ok) nto++;
    end
    checks++;
    if (nto != 0) begin failures++; $display("FAIL burst_accept timeouts=%0d required 0", nto); end
    repeat (600) begin
      @(negedge clk);
      if (ntx_done == nbase + 2) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL burst_done got %0d bursts required 2", ntx_done - nbase); end
    checks++;
    if (wlog.size() - base != 14) begin
      failures++; $display("FAIL burst_write_count got %0d required 14", wlog.size() - base);
    end
    for (int i = 0; i < 14; i++) begin
      if (i < 8)                 x = {8'(nbase), 8'd4, 24'd0, 8'h30 + 8'(i)};
      else if (i == 8)           x = {8'(nbase), 8'd28, 32'd1};
      else if (i == 9)           x = {8'(nbase), 8'd16, 32'd1};
      else if (i < 12)           x = {8'(nbase + 1), 8'd4, 24'd0, 8'h30 + 8'(i - 2)};
      else if (i == 12)          x = {8'(nbase + 1), 8'd28, 32'd1};
      else                       x = {8'(nbase + 1), 8'd16, 32'd1};
      e = (base + i < wlog.size()) ? wlog[base + i] : '1;
      checks++;
      if (e !== x) begin failures++; $display("FAIL burst_write[%0d] got %h required %h", i, e, x); end
    end
    checks++;
    if (sent.size() - sbase != 10) begin
      failures++; $display("FAIL burst_serial_count got %0d required 10", sent.size() - sbase);
    end
  endtask

  task automatic test_loopback();
    int gbase;
    bit ok;
    loopback = 1'b1;
    rx_ready_i = 1'b1;
    gbase = got.size();
    push_byte(8'hA5, ok);
    repeat (300) @(negedge clk);
    checks++;
    if (!ok || got.size() - gbase != 1) begin
      failures++; $display("FAIL loop_count got %0d deliveries accepted=%b required 1", got.size() - gbase, ok);
    end
    checks++;
    if (got.size() <= gbase || got[gbase] !== 8'hA5) begin
      failures++; $display("FAIL loop_data got %h required a5", (got.size() > gbase) ? got[gbase] : 8'hxx);
    end
    checks++;
    if (rx_valid_o !== 1'b0) begin failures++; $display("FAIL loop_valid_clear got %b required 0", rx_valid_o); end
    loopback = 1'b0;
  endtask

  task automatic test_rx_backpressure();
    int gbase, rbase;
    @(posedge clk); #1;
    rx_ready_i = 1'b0;
    gbase = got.size(); rbase = nrd8;
    inj_data[inj_cnt] = 8'h11; inj_cnt++;
    inj_data[inj_cnt] = 8'h22; inj_cnt++;
    repeat (200) @(negedge clk);
    checks++;
    if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h11) begin
      failures++; $display("FAIL bp_hold got valid=%b data=%h required 1 11", rx_valid_o, rx_data_o);
    end
    checks++;
    if (nrd8 - rbase != 1 || rxq.size() != 1) begin
      failures++; $display("FAIL bp_no_second_read got reads=%0d fifo=%0d required 1 1", nrd8 - rbase, rxq.size());
    end
    @(posedge clk); #1;
    rx_ready_i = 1'b1;
    repeat (200) @(negedge clk);
    checks++;
    if (got.size() - gbase != 2) begin
      failures++; $display("FAIL bp_count got %0d required 2", got.size() - gbase);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got.size() <= gbase + i || got[gbase + i] !== ((i == 0) ? 8'h11 : 8'h22)) begin
        failures++; $display("FAIL bp_order[%0d] got %h required %h", i,
                             (got.size() > gbase + i) ? got[gbase + i] : 8'hxx, (i == 0) ? 8'h11 : 8'h22);
      end
    end
    checks++;
    if (rxq.size() != 0 || rx_valid_o !== 1'b0) begin
      failures++; $display("FAIL bp_drained got fifo=%0d valid=%b required 0 0", rxq.size(), rx_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [39:0] last;
    hold_tx = 1'b1;
    push_byte(8'h77, ok);
    repeat (20) @(negedge clk);
    last = (wlog.size() > 0) ? wlog[wlog.size() - 1][39:0] : '0;
    checks++;
    if (!ok || busy_o !== 1'b1 || last !== {8'd16, 32'd1}) begin
      failures++; $display("FAIL mid_in_txwait got busy=%b last=%h accepted=%b required 1 1000000001 1",
                           busy_o, last, ok);
    end
    @(posedge clk); #1;
    rst_ni = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_o, ren_o, we_o, tx_ready_o, rx_valid_o} !== 5'b0 || addr_o !== 8'd0 || wdata_o !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs got busy=%b ren=%b we=%b rdy=%b rxv=%b addr=%h wdata=%h required all 0",
               busy_o, ren_o, we_o, tx_ready_o, rx_valid_o, addr_o, wdata_o);
    end
    hold_tx = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (we_o !== 1'b1 || addr_o !== CFG_A[i] || wdata_o !== CFG_D[i]) begin
        failures++;
        $display("FAIL mid_recfg[%0d] got we=%b addr=%0d data=%0d required we=1 addr=%0d data=%0d",
                 i, we_o, addr_o, wdata_o, CFG_A[i], CFG_D[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL mid_recfg_idle got busy=%b required 0", busy_o); end
  endtask

  task automatic test_bus_rules();
    checks++;
    if (viol != 0) begin failures++; $display("FAIL bus_rules got %0d violations required 0", viol); end
  endtask

  initial begin
    rst_ni     = 1'b0;
    tx_valid_i = 1'b0;
    tx_data_i  = '0;
    rx_ready_i = 1'b0;
    test_reset();
    test_tx3();
    test_burst10();
    test_loopback();
    test_rx_backpressure();
    test_reset_mid();
    test_bus_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
